life_cell_gen: RTL
==================

Name: life_cell_gen

Overview:
- Parametrised, registered successor to the team's combinational Life cell.
- Holds its own state register and applies a run-time programmable birth/survival rule (B/S masks) to a neighbour count of configurable size.
- Supports multi-state "Generations" decay and tracks a saturating age, a change pulse and the next-state value.
- One instance per grid site in the game-of-life array; neighbour `alive` outputs are wired to each other's `neighbors` inputs.

Parameters:
- N_NEIGHBORS, 8: number of neighbour inputs (4 = von Neumann, 8 = Moore; any value from 1 to 24).
- GEN_STATES, 2: total cell states. 2 gives classic Life; values above 2 enable refractory (dying) states. Legal range is 2 to 16.
- AGE_W, 4: width of the age counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  advance one generation on this clock edge.
- load  in  1  synchronous initialise; has priority over ena.
- state_init  in  1  value loaded on load (1 = alive, 0 = dead).
- birth_mask  in  N_NEIGHBORS+1  bit k=1 means a dead cell with k live neighbours is born.
- survive_mask  in  N_NEIGHBORS+1  bit k=1 means a live cell with k live neighbours survives.
- neighbors  in  N_NEIGHBORS  alive flags of adjacent cells.
- alive  out  1  registered; 1 iff state_q==1.
- alive_d  out  1  combinational; alive value the next ena edge would produce.
- state_q  out  SW  registered state, where SW = max(1, clog2(GEN_STATES)).
- age  out  AGE_W  consecutive enabled generations survived while alive.
- changed  out  1  registered one-cycle pulse when state_q changed on the last ena edge.

Behaviour:
- Count rule: count = popcount(neighbors), width clog2(N_NEIGHBORS+1). The count indexes the masks directly (count 0 to N). No overflow is possible.
- State encoding: 0 = dead, 1 = alive, 2 to GEN_STATES-1 = dying. Only state 1 drives alive; dying cells are not counted as live by neighbours.
- Next state (nxt):
  - From state 0: 1 if birth_mask[count], otherwise 0.
  - From state 1: 1 if survive_mask[count]; otherwise 0 when GEN_STATES==2, else 2.
  - From dying state s: s+1 if s < GEN_STATES-1, otherwise 0. Neighbours and masks are ignored; a dying cell cannot be reborn until it reaches 0.
- alive_d = (nxt==1). It is purely combinational from state_q, neighbors and the masks, with zero latency.
- Register update on each clk rising edge, in priority order:
  1. load=1: state_q <= {0, state_init}; age <= 0; changed <= (state_q != {0, state_init}). ena is ignored.
  2. ena=1: state_q <= nxt; changed <= (nxt != state_q). age is incremented, saturating at 2^AGE_W-1, when state_q==1 and nxt==1; otherwise age <= 0.
  3. Otherwise: state_q and age hold; changed <= 0.
- changed is high for exactly one cycle per effective transition, then clears on the next edge unless another transition occurs.
- Latency: one clock from ena/load to alive, state_q, age and changed.
- Reset: on rst low, immediately and without a clock, state_q=0, age=0, changed=0, alive=0. alive_d then reflects birth_mask[count]. Reset asserted mid-decay or mid-age-count clears everything. The first edge after rst deasserts behaves normally.
- Mask changes take effect on the very next ena edge; no internal copy of the masks is kept.
- Out-of-range states (cannot occur after reset) must decode to 0 on the next ena.

Test Plan:
- B3/S23 rule (birth_mask=9'b000001000, survive_mask=9'b000001100), GEN_STATES=2. Dead cell, neighbors=8'b00010101, ena pulse -> alive_d=1 before the edge; after the edge alive=1, state_q=1, changed=1 for one cycle, age=0.
- Same rule, alive cell with 2 live neighbours, ena for 3 cycles -> alive stays 1, age = 1, 2, 3, changed=0. Then neighbours set to 4 live, ena -> alive=0, age=0, changed=1.
- GEN_STATES=4, alive cell with 0 neighbours, ena for 3 cycles -> state_q = 2, 3, 0 and alive=0 throughout. Holding 3 live neighbours during states 2 and 3 must not cause a birth; birth happens only on the edge after state 0 is reached.
- AGE_W=2, alive cell with 3 neighbours, ena for 5 cycles -> age = 1, 2, 3, 3, 3 (saturates).
- Priority and hold cases:
  - load=1 with state_init=1 and ena=1 on a cell whose count would make it die -> alive=1, age=0.
  - ena=0 for 4 cycles -> state and age unchanged, changed=0.
  - rst pulled low between edges -> alive=0 and age=0 immediately, with no clock edge.
- HighLife masks (birth_mask=9'b001001000) with 6 live neighbours on a dead cell -> born. N_NEIGHBORS=4 instance with birth_mask=5'b00100 and 2 live neighbours -> born.

Source files
------------

// File: rtl/life_cell_gen.sv
// Registered Life cell with programmable B/S rule, Generations decay,
// saturating age counter and change pulse.
module life_cell_gen #(
    parameter int N_NEIGHBORS = 8,
    parameter int GEN_STATES  = 2,
    parameter int AGE_W       = 4,
    localparam int SW = (GEN_STATES > 2) ? $clog2(GEN_STATES) : 1,
    localparam int CW = $clog2(N_NEIGHBORS + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   load,
    input  logic                   state_init,
    input  logic [N_NEIGHBORS:0]   birth_mask,
    input  logic [N_NEIGHBORS:0]   survive_mask,
    input  logic [N_NEIGHBORS-1:0] neighbors,
    output logic                   alive,
    output logic                   alive_d,
    output logic [SW-1:0]          state_q,
    output logic [AGE_W-1:0]       age,
    output logic                   changed
);

    localparam logic [SW-1:0] ST_DEAD  = '0;
    localparam logic [SW-1:0] ST_ALIVE = SW'(1);
    localparam logic [SW-1:0] ST_DYING = (GEN_STATES > 2) ? SW'(2) : ST_DEAD;
    localparam logic [SW-1:0] ST_LAST  = SW'(GEN_STATES - 1);

    logic [CW-1:0]    count;
    logic [SW-1:0]    nxt;
    logic [SW-1:0]    init_val;
    logic [AGE_W-1:0] age_max;

    always_comb begin
        count = '0;
        for (int i = 0; i < N_NEIGHBORS; i++) begin
            count = count + CW'(neighbors[i]);
        end
    end

    // Anything at or past the last dying state (incl. unreachable codes) wraps to dead.
    always_comb begin
        nxt = ST_DEAD;
        if (state_q == ST_DEAD) begin
            nxt = birth_mask[count] ? ST_ALIVE : ST_DEAD;
        end else if (state_q == ST_ALIVE) begin
            nxt = survive_mask[count] ? ST_ALIVE : ST_DYING;
        end else if (state_q < ST_LAST) begin
            nxt = state_q + SW'(1);
        end
    end

    assign alive_d  = (nxt == ST_ALIVE);
    assign alive    = (state_q == ST_ALIVE);
    assign init_val = SW'(state_init);
    assign age_max  = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_DEAD;
            age     <= '0;
            changed <= 1'b0;
        end else if (load) begin
            state_q <= init_val;
            age     <= '0;
            changed <= (state_q != init_val);
        end else if (ena) begin
            state_q <= nxt;
            changed <= (nxt != state_q);
            if (state_q == ST_ALIVE && nxt == ST_ALIVE) begin
                if (age != age_max) begin
                    age <= age + AGE_W'(1);
                end
            end else begin
                age <= '0;
            end
        end else begin
            changed <= 1'b0;
        end
    end

endmodule
